// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// the XLEN-dependent decode helpers used by the FSM and the lane aligner.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic int strb_width(input int xlen);
    return xlen / 8;
  endfunction

  function automatic int off_width(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  // Width codes that do not exist for this access type or datapath width.
  function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                          input int xlen);
    return (f3 == 3'b111) || (we && f3[2]) ||
           ((xlen == 32) && ((f3 == F3_D) || (f3 == F3_WU)));
  endfunction

  // size_log2 selects 1/2/4/8 bytes; any set address bit below that is misaligned.
  function automatic logic misaligned(input logic [2:0] low, input logic [1:0] size_log2);
    logic [2:0] mask;
    mask = 3'((4'd1 << size_log2) - 4'd1);
    return |(low & mask);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extract + extend.
// Purely combinational; both paths are independent.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 64,
  localparam int SW   = strb_width(XLEN),
  localparam int OW   = off_width(XLEN)
) (
  input  logic [1:0]      st_size,
  input  logic [OW-1:0]   st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [SW-1:0]   st_wstrb,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic [1:0]      ld_size,
  input  logic [OW-1:0]   ld_off,
  input  logic            ld_signed,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] shifted;
  logic            sign_bit;
  logic            fill;

  assign st_wdata = st_data << {st_off, 3'b000};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    st_wstrb = '0;
    for (int i = 0; i < SW; i++) begin
      st_wstrb[i] = (i >= int'(st_off)) && (i < int'(st_off) + (1 << st_size));
    end
  end

  // Top byte of the selected width supplies the sign for signed loads.
  always_comb begin
    shifted  = ld_rdata >> {ld_off, 3'b000};
    sign_bit = 1'b0;
    ld_data  = '0;
    for (int i = 0; i < SW; i++) begin
      if (i == (1 << ld_size) - 1) sign_bit = shifted[8*i+7];
    end
    fill = ld_signed & sign_bit;
    for (int i = 0; i < SW; i++) begin
      ld_data[8*i +: 8] = (i < (1 << ld_size)) ? shifted[8*i +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: registered valid/ready bridge from execute to a stallable
// memory port, with decode-time error detection and a request timeout.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int SW = strb_width(XLEN);
  localparam int OW = off_width(XLEN);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
  logic [SW-1:0]   mem_wstrb_q;
  logic [1:0]      size_q;
  logic [OW-1:0]   off_q;
  logic            signed_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;

  logic            dec_err;
  logic            timeout;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [SW-1:0]   st_wstrb;

  assign dec_err = access_illegal(req_we, req_funct3, XLEN) ||
                   misaligned(req_addr[2:0], req_funct3[1:0]);
  assign timeout = (cnt_q == CNT_LAST);

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size   (req_funct3[1:0]),
    .st_off    (req_addr[OW-1:0]),
    .st_data   (req_wdata),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_rdata  (mem_rdata),
    .ld_size   (size_q),
    .ld_off    (off_q),
    .ld_signed (signed_q),
    .ld_data   (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // A response in WAIT wins over a timeout expiring in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = dec_err ? S_RESP : S_REQ;
      S_REQ: begin
        if (timeout)            state_d = S_RESP;
        else if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: if (mem_rsp_valid || timeout) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The bus-facing fields are captured once at acceptance so they stay
  // stable for the whole REQ phase; rsp fields are nonzero only in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      size_q      <= '0;
      off_q       <= '0;
      signed_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cnt_q       <= '0;
            mem_we_q    <= req_we;
            mem_addr_q  <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
            mem_wdata_q <= st_wdata;
            mem_wstrb_q <= st_wstrb;
            size_q      <= req_funct3[1:0];
            off_q       <= req_addr[OW-1:0];
            signed_q    <= ~req_funct3[2];
            rsp_rdata_q <= '0;
            rsp_err_q   <= dec_err;
          end
        end
        S_REQ, S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (state_q == S_WAIT && mem_rsp_valid) begin
            rsp_rdata_q <= mem_we_q ? '0 : ld_data;
            rsp_err_q   <= 1'b0;
          end else if (timeout) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end
        end
        S_RESP: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: three instances (64-bit default timeout,
// 64-bit short timeout, 32-bit) against a byte-arithmetic reference model.
module tb_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  rv;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        mem_req_ready, mem_rsp_valid;
  logic [63:0] mem_rdata;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_req_valid, a_mem_we;
  logic [63:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [7:0]  a_mem_wstrb;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_req_valid, b_mem_we;
  logic [63:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [7:0]  b_mem_wstrb;
  logic        c_req_ready, c_rsp_valid, c_rsp_err, c_mem_req_valid, c_mem_we;
  logic [31:0] c_rsp_rdata, c_mem_addr, c_mem_wdata;
  logic [3:0]  c_mem_wstrb;

  lsu #(.XLEN(64), .TIMEOUT(255)) u_a (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(a_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata));

  lsu #(.XLEN(64), .TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(b_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata));

  lsu #(.XLEN(32), .TIMEOUT(255)) u_c (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(c_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err),
    .mem_req_valid(c_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(c_mem_we),
    .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_wstrb(c_mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]));

  // Observation mux: the instance under test is selected by sel.
  int          sel;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_req_valid, o_mem_we;
  logic [63:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wstrb;

  always_comb begin
    o_req_ready = a_req_ready;  o_rsp_valid = a_rsp_valid;  o_rsp_err = a_rsp_err;
    o_mem_req_valid = a_mem_req_valid;  o_mem_we = a_mem_we;  o_rsp_rdata = a_rsp_rdata;
    o_mem_addr = a_mem_addr;  o_mem_wdata = a_mem_wdata;  o_mem_wstrb = a_mem_wstrb;
    if (sel == 1) begin
      o_req_ready = b_req_ready;  o_rsp_valid = b_rsp_valid;  o_rsp_err = b_rsp_err;
      o_mem_req_valid = b_mem_req_valid;  o_mem_we = b_mem_we;  o_rsp_rdata = b_rsp_rdata;
      o_mem_addr = b_mem_addr;  o_mem_wdata = b_mem_wdata;  o_mem_wstrb = b_mem_wstrb;
    end else if (sel == 2) begin
      o_req_ready = c_req_ready;  o_rsp_valid = c_rsp_valid;  o_rsp_err = c_rsp_err;
      o_mem_req_valid = c_mem_req_valid;  o_mem_we = c_mem_we;
      o_rsp_rdata = {32'd0, c_rsp_rdata};  o_mem_addr = {32'd0, c_mem_addr};
      o_mem_wdata = {32'd0, c_mem_wdata};  o_mem_wstrb = {4'd0, c_mem_wstrb};
    end
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } exp_t;

  // Reference model: access semantics from plain byte arithmetic.
  function automatic exp_t model(input int xlen, input logic we, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] mem);
    exp_t e;
    int nb, lanes, off;
    logic [127:0] v, mask;
    logic [63:0] xmask;
    nb    = 1 << f3[1:0];
    lanes = xlen / 8;
    xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e.err = (f3 == 3'b111) || (we && f3[2]) ||
            (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110)) || (addr % nb != 0);
    off     = int'(addr % lanes);
    e.addr  = (addr - 64'(off)) & xmask;
    e.strb  = 8'(((1 << nb) - 1) << off);
    e.wdata = (wdata << (8 * off)) & xmask;
    mask    = (128'd1 << (8 * nb)) - 128'd1;
    v       = ({64'd0, mem & xmask} >> (8 * off)) & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    e.rdata = (we || e.err) ? 64'd0 : (v[63:0] & xmask);
    return e;
  endfunction

  // One access on instance s with a memory that holds off ready for rdy_dly
  // REQ cycles and answers rsp_dly cycles after the handshake.
  task automatic run_access(input int s, input logic we, input logic [2:0] f3,
                            input logic [63:0] addr_in, input logic [63:0] wdata_in,
                            input logic [63:0] mem_in, input int rdy_dly,
                            input int rsp_dly, input string tag);
    exp_t e;
    int xlen, to, exp_lat, lat, seen_req, wait_n;
    logic [63:0] addr, wdata, mem;
    bit got, handshaken, seen_mreq, unstable;
    xlen  = (s == 2) ? 32 : 64;
    to    = (s == 1) ? 8 : 255;
    addr  = (s == 2) ? {32'd0, addr_in[31:0]} : addr_in;
    wdata = (s == 2) ? {32'd0, wdata_in[31:0]} : wdata_in;
    mem   = mem_in;
    e = model(xlen, we, f3, addr, wdata, mem);
    if (e.err) exp_lat = 1;
    else if (rdy_dly + rsp_dly + 2 > to) begin
      exp_lat = to + 1;
      e.err   = 1'b1;
      e.rdata = 64'd0;
    end else exp_lat = rdy_dly + rsp_dly + 3;

    @(negedge clk);
    sel = s;  req_we = we;  req_funct3 = f3;  req_addr = addr_in;  req_wdata = wdata_in;
    rv = 3'b000;  rv[s] = 1'b1;
    #1;
    n_vec++;
    if (o_req_ready !== 1'b1) begin
      n_err++;  $display("FAIL %s req_ready before accept: got %b want 1", tag, o_req_ready);
    end
    @(posedge clk);
    #1 rv = 3'b000;

    got = 0;  handshaken = 0;  seen_mreq = 0;  unstable = 0;
    lat = 0;  seen_req = 0;  wait_n = 0;
    for (int k = 1; k <= 300 && !got; k++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;  mem_rsp_valid = 1'b0;  mem_rdata = {$urandom, $urandom};
      if (o_rsp_valid) begin
        got = 1;  lat = k;
      end else if (o_mem_req_valid) begin
        seen_mreq = 1;
        if ({o_mem_addr, o_mem_wdata, o_mem_wstrb, o_mem_we} !== {e.addr, e.wdata, e.strb, we})
          unstable = 1;
        if (seen_req == rdy_dly) begin mem_req_ready = 1'b1;  handshaken = 1; end
        seen_req++;
      end else if (handshaken) begin
        if (wait_n == rsp_dly) begin mem_rsp_valid = 1'b1;  mem_rdata = mem; end
        wait_n++;
      end
    end

    n_vec++;
    if (!got || lat != exp_lat) begin
      n_err++;  $display("FAIL %s rsp latency: got %0d want %0d (seen=%0d)", tag, lat, exp_lat, got);
    end
    n_vec++;
    if (got && {o_rsp_err, o_rsp_rdata, o_req_ready} !== {e.err, e.rdata, 1'b0}) begin
      n_err++;
      $display("FAIL %s rsp: got err=%b data=%h ready=%b want err=%b data=%h ready=0",
               tag, o_rsp_err, o_rsp_rdata, o_req_ready, e.err, e.rdata);
    end
    n_vec++;
    if (seen_mreq !== (exp_lat == 1 ? 1'b0 : 1'b1) || unstable) begin
      n_err++;
      $display("FAIL %s mem request: seen=%b unstable=%b addr=%h wdata=%h strb=%h want addr=%h wdata=%h strb=%h",
               tag, seen_mreq, unstable, o_mem_addr, o_mem_wdata, o_mem_wstrb, e.addr, e.wdata, e.strb);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;  mem_rsp_valid = 1'b0;
    n_vec++;
    if ({o_rsp_valid, o_req_ready, o_rsp_err} !== 3'b010) begin
      n_err++;
      $display("FAIL %s after rsp: got valid=%b ready=%b err=%b want 0 1 0",
               tag, o_rsp_valid, o_req_ready, o_rsp_err);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_vec++;
      if ({o_req_ready, o_rsp_valid, o_rsp_err, o_mem_req_valid, o_mem_we,
           o_rsp_rdata, o_mem_addr, o_mem_wdata, o_mem_wstrb} !== {1'b1, 4'b0, 200'd0}) begin
        n_err++;
        $display("FAIL %s dut%0d: got ready=%b valid=%b err=%b mreq=%b we=%b rdata=%h addr=%h wdata=%h strb=%h want ready=1 rest 0",
                 tag, s, o_req_ready, o_rsp_valid, o_rsp_err, o_mem_req_valid, o_mem_we,
                 o_rsp_rdata, o_mem_addr, o_mem_wdata, o_mem_wstrb);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed;
    logic [63:0] hi;
    hi = {16'h8001, 16'($urandom), $urandom};
    run_access(0, 1'b1, 3'b000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'd0, 0, 0, "sb");
    run_access(0, 1'b0, 3'b001, 64'h8000_0006, 64'd0, hi, 0, 0, "lh");
    run_access(0, 1'b0, 3'b101, 64'h8000_0006, 64'd0, hi, 0, 0, "lhu");
    run_access(0, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 0, "lw_misaligned");
    run_access(0, 1'b0, 3'b011, 64'h8000_0008, 64'd0, 64'hFEDC_BA98_7654_3210, 3, 5, "ld_stall");
    run_access(0, 1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 0, 0, "f3_111");
    run_access(0, 1'b1, 3'b100, 64'h8000_0000, 64'd0, 64'd0, 0, 0, "store_unsigned");
    run_access(0, 1'b0, 3'b000, 64'h8000_0007, 64'd0, 64'h80FF_FFFF_FFFF_FFFF, 1, 0, "lb_top_lane");
    run_access(0, 1'b1, 3'b011, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'd0, 0, 2, "sd");
  endtask

  task automatic test_random;
    logic [63:0] addr;
    logic [2:0]  f3;
    for (int i = 0; i < 60; i++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(1 << f3[1:0]) - 64'd1);
      run_access(0, 1'($urandom_range(0, 1)), f3, addr, {$urandom, $urandom},
                 {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 4), "random64");
    end
  endtask

  task automatic test_timeout;
    run_access(1, 1'b0, 3'b011, 64'h8000_0000, 64'd0, 64'd0, 2, 1000, "timeout_wait");
    run_access(1, 1'b1, 3'b010, 64'h8000_0004, 64'h1234, 64'd0, 1000, 0, "timeout_req");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({o_rsp_valid, o_req_ready, o_mem_req_valid} !== 3'b010) begin
        n_err++;
        $display("FAIL stale_rsp cycle %0d: got valid=%b ready=%b mreq=%b want 0 1 0",
                 i, o_rsp_valid, o_req_ready, o_mem_req_valid);
      end
      mem_rsp_valid = (i < 2);  mem_rdata = {$urandom, $urandom};
    end
    @(negedge clk) mem_rsp_valid = 1'b0;
    run_access(1, 1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 1, "after_timeout");
  endtask

  task automatic test_xlen32;
    run_access(2, 1'b0, 3'b011, 64'h8000_0000, 64'd0, 64'd0, 0, 0, "rv32_ld");
    run_access(2, 1'b0, 3'b110, 64'h8000_0000, 64'd0, 64'd0, 0, 0, "rv32_lwu");
    for (int i = 0; i < 12; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      run_access(2, 1'($urandom_range(0, 1)), f3,
                 {$urandom, $urandom} & ~(64'(1 << f3[1:0]) - 64'd1), {$urandom, $urandom},
                 {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), "random32");
    end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    sel = 2;  req_we = 1'b0;  req_funct3 = 3'b010;  req_addr = 64'h8000_0004;  rv = 3'b100;
    @(posedge clk);
    #1 rv = 3'b000;
    @(negedge clk) mem_req_ready = 1'b1;
    @(negedge clk) mem_req_ready = 1'b0;
    n_vec++;
    if ({o_mem_req_valid, o_rsp_valid, o_req_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid wait state: got mreq=%b valid=%b ready=%b want 0 0 0",
               o_mem_req_valid, o_rsp_valid, o_req_ready);
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    mem_rsp_valid = 1'b1;  mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;  rst = 1'b1;
    sel = 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL reset_mid no rsp cycle %0d: got valid=%b ready=%b want 0 1",
                 i, o_rsp_valid, o_req_ready);
      end
    end
    run_access(2, 1'b0, 3'b010, 64'h8000_0004, 64'd0, 64'h0000_0000_8000_1234, 0, 0, "post_reset_lw");
  endtask

  initial begin
    rv = 3'b000;  sel = 0;  req_we = 1'b0;  req_funct3 = 3'b000;
    req_addr = 64'd0;  req_wdata = 64'd0;
    mem_req_ready = 1'b0;  mem_rsp_valid = 1'b0;  mem_rdata = 64'd0;
    test_reset;
    test_directed;
    test_random;
    test_timeout;
    test_xlen32;
    test_reset_mid_access;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
